// File: rtl/pcie_egress_arbiter_pkg.sv
// pcie_egress_arbiter_pkg: shared state encoding and TLP header field widths for the egress arbiter
package pcie_egress_arbiter_pkg;
  localparam int CMD_W = 8;
  localparam int FLAGS_W = 14;
  localparam int ADDR_W = 32;
  localparam int RID_W = 16;
  localparam int TAG_W = 8;
  localparam int SIZE_W = 24;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE} state_t;
  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [FLAGS_W-1:0] flags;
    logic [ADDR_W-1:0] addr;
    logic [RID_W-1:0] rid;
    logic [TAG_W-1:0] tag;
  } hdr_t;
endpackage

// File: rtl/pcie_egress_rr_select.sv
// pcie_egress_rr_select: combinational round-robin picker, first valid index after last_i
module pcie_egress_rr_select #(
  parameter int NUM_REQ = 3,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IW-1:0]      last_i,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);
  logic [IW-1:0] j;
  assign any_o = |valid_i;
  // scan from farthest to nearest so the requester right after last_i wins
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = IW'((int'(last_i) + k) % NUM_REQ);
      if (valid_i[j]) idx_o = j;
    end
  end
endmodule

// File: rtl/pcie_egress_arbiter.sv
// pcie_egress_arbiter: round-robin share of the PCIe egress TLP engine; PCIE_EGRESS_ARB_WATCHDOG_EN adds an ISSUE timeout
module pcie_egress_arbiter
  import pcie_egress_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*CMD_W-1:0]  i_req_command,
  input  logic [NUM_REQ*FLAGS_W-1:0] i_req_flags,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_address,
  input  logic [NUM_REQ*RID_W-1:0]  i_req_requester_id,
  input  logic [NUM_REQ*TAG_W-1:0]  i_req_tag,
  output logic [NUM_REQ-1:0]        o_req_grant,
  output logic [NUM_REQ-1:0]        o_req_done,
  output logic [NUM_REQ-1:0]        o_req_error,
  input  logic [NUM_REQ-1:0]        i_req_fifo_rdy,
  input  logic [NUM_REQ*SIZE_W-1:0] i_req_fifo_size,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_fifo_data,
  output logic [NUM_REQ-1:0]        o_req_fifo_act,
  output logic [NUM_REQ-1:0]        o_req_fifo_stb,
  output logic                      o_egress_enable,
  input  logic                      i_egress_finished,
  output logic [CMD_W-1:0]          o_egress_command,
  output logic [FLAGS_W-1:0]        o_egress_flags,
  output logic [ADDR_W-1:0]         o_egress_address,
  output logic [RID_W-1:0]          o_egress_requester_id,
  output logic [TAG_W-1:0]          o_egress_tag,
  output logic                      o_egress_fifo_rdy,
  output logic [SIZE_W-1:0]         o_egress_fifo_size,
  output logic [DATA_W-1:0]         o_egress_fifo_data,
  input  logic                      i_egress_fifo_act,
  input  logic                      i_egress_fifo_stb,
  output logic                      o_busy
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state_q, state_d;
  logic [IW-1:0] sel_q, sel_d, last_q, last_d, pick;
  logic any, en_q, en_d, busy, f_rdy;
  hdr_t hdr_q, hdr_d, pick_hdr;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d, sel_oh;
  logic [SIZE_W-1:0] f_size;
  logic [DATA_W-1:0] f_data;
  pcie_egress_rr_select #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid_i(i_req_valid),
    .last_i (last_q),
    .idx_o  (pick),
    .any_o  (any)
  );
  assign busy = state_q != S_IDLE;
  assign sel_oh = NUM_REQ'(1) << sel_q;
  // slice out the picked requester's header and the selected requester's FIFO
  always_comb begin
    pick_hdr = '0;
    f_rdy = 1'b0;
    f_size = '0;
    f_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick == IW'(k)) pick_hdr = {i_req_command[k*CMD_W +: CMD_W], i_req_flags[k*FLAGS_W +: FLAGS_W], i_req_address[k*ADDR_W +: ADDR_W], i_req_requester_id[k*RID_W +: RID_W], i_req_tag[k*TAG_W +: TAG_W]};
      if (sel_q == IW'(k)) begin
        f_rdy = i_req_fifo_rdy[k];
        f_size = i_req_fifo_size[k*SIZE_W +: SIZE_W];
        f_data = i_req_fifo_data[k*DATA_W +: DATA_W];
      end
    end
  end
`ifdef PCIE_EGRESS_ARB_WATCHDOG_EN
  logic [31:0] cnt_q, cnt_d;
  logic abort_q, abort_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  // watchdog counter, abort flag and error pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      abort_q <= 1'b0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      abort_q <= abort_d;
      err_q <= err_d;
    end
  assign o_req_error = err_q;
`else
  assign o_req_error = '0;
`endif
  // arbitration FSM next state: grant in IDLE, wait finished high, then finished low
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    last_d = last_q;
    hdr_d = hdr_q;
    en_d = en_q;
    grant_d = '0;
    done_d = '0;
`ifdef PCIE_EGRESS_ARB_WATCHDOG_EN
    cnt_d = cnt_q;
    abort_d = abort_q;
    err_d = '0;
`endif
    case (state_q)
      S_IDLE: if (any) begin
        sel_d = pick;
        hdr_d = pick_hdr;
        grant_d = NUM_REQ'(1) << pick;
        en_d = 1'b1;
        state_d = S_ISSUE;
`ifdef PCIE_EGRESS_ARB_WATCHDOG_EN
        cnt_d = '0;
`endif
      end
      S_ISSUE: if (i_egress_finished) begin
        en_d = 1'b0;
        state_d = S_RELEASE;
      end
`ifdef PCIE_EGRESS_ARB_WATCHDOG_EN
      else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
        en_d = 1'b0;
        abort_d = 1'b1;
        state_d = S_RELEASE;
      end else cnt_d = cnt_q + 32'd1;
`endif
      S_RELEASE: if (!i_egress_finished) begin
        done_d = sel_oh;
        last_d = sel_q;
        state_d = S_IDLE;
`ifdef PCIE_EGRESS_ARB_WATCHDOG_EN
        err_d = abort_q ? sel_oh : '0;
        abort_d = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end
  // FSM state and registered outputs; reset starts rotation at requester 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      sel_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
      hdr_q <= '0;
      en_q <= 1'b0;
      grant_q <= '0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      last_q <= last_d;
      hdr_q <= hdr_d;
      en_q <= en_d;
      grant_q <= grant_d;
      done_q <= done_d;
    end
  assign o_req_grant = grant_q;
  assign o_req_done = done_q;
  assign o_egress_enable = en_q;
  assign o_busy = busy;
  assign o_egress_command = hdr_q.cmd;
  assign o_egress_flags = hdr_q.flags;
  assign o_egress_address = hdr_q.addr;
  assign o_egress_requester_id = hdr_q.rid;
  assign o_egress_tag = hdr_q.tag;
  assign o_egress_fifo_rdy = busy & f_rdy;
  assign o_egress_fifo_size = busy ? f_size : '0;
  assign o_egress_fifo_data = busy ? f_data : '0;
  assign o_req_fifo_act = busy ? sel_oh & {NUM_REQ{i_egress_fifo_act}} : '0;
  assign o_req_fifo_stb = busy ? sel_oh & {NUM_REQ{i_egress_fifo_stb}} : '0;
endmodule

// File: tb/tb_pcie_egress_arbiter.sv
// tb_pcie_egress_arbiter: directed vectors for rotation, FIFO routing, reset and the optional watchdog
module tb_pcie_egress_arbiter;
  localparam int N = 3;
  localparam int TO = 24;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_fifo_rdy = '0;
  logic [N*8-1:0] req_command, req_tag;
  logic [N*14-1:0] req_flags;
  logic [N*32-1:0] req_address, req_fifo_data;
  logic [N*16-1:0] req_rid;
  logic [N*24-1:0] req_fifo_size;
  logic egress_finished = 1'b0, egress_fifo_act = 1'b0, egress_fifo_stb = 1'b0;
  logic [N-1:0] o_req_grant, o_req_done, o_req_error, o_req_fifo_act, o_req_fifo_stb;
  logic o_egress_enable, o_egress_fifo_rdy, o_busy;
  logic [7:0] o_egress_command, o_egress_tag;
  logic [13:0] o_egress_flags;
  logic [31:0] o_egress_address, o_egress_fifo_data;
  logic [15:0] o_egress_requester_id;
  logic [23:0] o_egress_fifo_size;
  pcie_egress_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .i_req_command(req_command), .i_req_flags(req_flags),
    .i_req_address(req_address), .i_req_requester_id(req_rid), .i_req_tag(req_tag),
    .o_req_grant(o_req_grant), .o_req_done(o_req_done), .o_req_error(o_req_error),
    .i_req_fifo_rdy(req_fifo_rdy), .i_req_fifo_size(req_fifo_size), .i_req_fifo_data(req_fifo_data),
    .o_req_fifo_act(o_req_fifo_act), .o_req_fifo_stb(o_req_fifo_stb),
    .o_egress_enable(o_egress_enable), .i_egress_finished(egress_finished),
    .o_egress_command(o_egress_command), .o_egress_flags(o_egress_flags),
    .o_egress_address(o_egress_address), .o_egress_requester_id(o_egress_requester_id),
    .o_egress_tag(o_egress_tag), .o_egress_fifo_rdy(o_egress_fifo_rdy),
    .o_egress_fifo_size(o_egress_fifo_size), .o_egress_fifo_data(o_egress_fifo_data),
    .i_egress_fifo_act(egress_fifo_act), .i_egress_fifo_stb(egress_fifo_stb), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int cyc = 0, last_gcyc = -100, done_cnt = 0;
  int stb_cnt[N];
  function automatic logic [7:0] f_cmd(int k); return k == 0 ? 8'h00 : 8'(8'h40 + k); endfunction
  function automatic logic [7:0] f_tag(int k); return k == 0 ? 8'h05 : 8'(8'h10 + k); endfunction
  function automatic logic [13:0] f_flags(int k); return 14'(14'h0100 + k); endfunction
  function automatic logic [31:0] f_addr(int k); return 32'h1000_0000 + 32'(k) * 32'h100; endfunction
  function automatic logic [15:0] f_rid(int k); return 16'(16'h0A00 + k); endfunction
  function automatic logic [23:0] f_size(int k); return k == 1 ? 24'd16 : 24'(k + 5); endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) cyc++;
  // grant spacing, done pulse and routed strobe bookkeeping
  always @(negedge clk) begin
    if (|o_req_grant) begin
      checks++;
      if (cyc - last_gcyc < 3) begin
        errors++;
        $display("FAIL grant_spacing actual=%0d expected>=3", cyc - last_gcyc);
      end
      last_gcyc = cyc;
    end
    if (|o_req_done) done_cnt++;
    for (int k = 0; k < N; k++) if (o_req_fifo_stb[k]) stb_cnt[k]++;
  end
  task automatic run_txn(input string nm, input logic [N-1:0] v, input int lat, input int exp);
    int n = 0;
    req_valid = v;
    step();
    while (o_req_grant == '0 && n < 8) begin
      step();
      n++;
    end
    chk({nm, "_grant"}, o_req_grant, N'(1) << exp);
    chk({nm, "_enable"}, o_egress_enable, 1);
    chk({nm, "_busy"}, o_busy, 1);
    chk({nm, "_cmd"}, o_egress_command, f_cmd(exp));
    chk({nm, "_tag"}, o_egress_tag, f_tag(exp));
    chk({nm, "_addr"}, o_egress_address, f_addr(exp));
    chk({nm, "_flags"}, o_egress_flags, f_flags(exp));
    chk({nm, "_rid"}, o_egress_requester_id, f_rid(exp));
    for (int i = 0; i < lat; i++) step();
    chk({nm, "_enable_held"}, o_egress_enable, 1);
    egress_finished = 1'b1;
    step();
    chk({nm, "_enable_low"}, o_egress_enable, 0);
    chk({nm, "_grant_pulse"}, o_req_grant, 0);
    chk({nm, "_busy_release"}, o_busy, 1);
    egress_finished = 1'b0;
    step();
    chk({nm, "_done"}, o_req_done, N'(1) << exp);
    chk({nm, "_error"}, o_req_error, 0);
    chk({nm, "_idle"}, o_busy, 0);
  endtask
  typedef struct {logic [N-1:0] valid; int lat; int exp;} vec_t;
  vec_t vecs[11];
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int s[N];
    int n, d0;
    vecs[0] = '{3'b001, 4, 0};
    vecs[1] = '{3'b111, 1, 1};
    vecs[2] = '{3'b111, 1, 2};
    vecs[3] = '{3'b111, 1, 0};
    vecs[4] = '{3'b111, 1, 1};
    vecs[5] = '{3'b111, 0, 2};
    vecs[6] = '{3'b100, 2, 2};
    vecs[7] = '{3'b110, 0, 1};
    vecs[8] = '{3'b101, 3, 2};
    vecs[9] = '{3'b011, 0, 0};
    vecs[10] = '{3'b110, 1, 1};
    for (int k = 0; k < N; k++) begin
      stb_cnt[k] = 0;
      req_command[k*8 +: 8] = f_cmd(k);
      req_tag[k*8 +: 8] = f_tag(k);
      req_flags[k*14 +: 14] = f_flags(k);
      req_address[k*32 +: 32] = f_addr(k);
      req_rid[k*16 +: 16] = f_rid(k);
      req_fifo_size[k*24 +: 24] = f_size(k);
      req_fifo_data[k*32 +: 32] = 32'hD000_0000 + 32'(k) * 32'h10000;
    end
    req_fifo_rdy = '1;
    repeat (3) step();
    chk("reset_enable", o_egress_enable, 0);
    chk("reset_grant", o_req_grant, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_tag", o_egress_tag, 0);
    chk("reset_fifo_rdy", o_egress_fifo_rdy, 0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 11; i++) run_txn($sformatf("vec%0d", i), vecs[i].valid, vecs[i].lat, vecs[i].exp);
    req_valid = '0;
    egress_fifo_act = 1'b1;
    egress_fifo_stb = 1'b1;
    #1;
    chk("idle_stb_blocked", o_req_fifo_stb, 0);
    chk("idle_act_blocked", o_req_fifo_act, 0);
    chk("idle_fifo_rdy", o_egress_fifo_rdy, 0);
    chk("idle_fifo_size", o_egress_fifo_size, 0);
    egress_fifo_act = 1'b0;
    egress_fifo_stb = 1'b0;
    req_valid = 3'b010;
    step();
    chk("fifo_grant", o_req_grant, 3'b010);
    req_valid = '0;
    chk("fifo_size", o_egress_fifo_size, 16);
    chk("fifo_rdy", o_egress_fifo_rdy, 1);
    egress_fifo_act = 1'b1;
    #1;
    chk("fifo_act", o_req_fifo_act, 3'b010);
    for (int k = 0; k < N; k++) s[k] = stb_cnt[k];
    for (int b = 0; b < 16; b++) begin
      req_fifo_data[32 +: 32] = 32'hD001_0000 + 32'(b);
      egress_fifo_stb = 1'b1;
      #1;
      chk($sformatf("fifo_data%0d", b), o_egress_fifo_data, 32'hD001_0000 + 32'(b));
      chk($sformatf("fifo_stb%0d", b), o_req_fifo_stb, 3'b010);
      step();
    end
    egress_fifo_stb = 1'b0;
    egress_fifo_act = 1'b0;
    chk("stb1_count", stb_cnt[1] - s[1], 16);
    chk("stb0_count", stb_cnt[0] - s[0], 0);
    chk("stb2_count", stb_cnt[2] - s[2], 0);
    egress_finished = 1'b1;
    step();
    egress_finished = 1'b0;
    step();
    chk("fifo_done", o_req_done, 3'b010);
    req_valid = 3'b100;
    step();
    chk("rst_grant", o_req_grant, 3'b100);
    req_valid = '0;
    step();
    step();
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("rst_async_enable", o_egress_enable, 0);
    chk("rst_async_busy", o_busy, 0);
    chk("rst_async_tag", o_egress_tag, 0);
    chk("rst_async_addr", o_egress_address, 0);
    step();
    step();
    rst = 1'b0;
    req_valid = 3'b111;
    step();
    chk("rst_no_done", done_cnt, d0);
    chk("rst_req0_first", o_req_grant, 3'b001);
    req_valid = '0;
    egress_finished = 1'b1;
    step();
    egress_finished = 1'b0;
    step();
    chk("rst_done0", o_req_done, 3'b001);
    req_valid = 3'b010;
    step();
    chk("wd_grant", o_req_grant, 3'b010);
    req_valid = '0;
`ifdef PCIE_EGRESS_ARB_WATCHDOG_EN
    n = 0;
    while (o_egress_enable && n < 3 * TO) begin
      n++;
      step();
    end
    chk("wd_enable_cycles", n, TO);
    chk("wd_busy_release", o_busy, 1);
    step();
    chk("wd_done", o_req_done, 3'b010);
    chk("wd_error", o_req_error, 3'b010);
`else
    n = 0;
    repeat (3 * TO) step();
    chk("nowd_enable_held", o_egress_enable, 1);
    chk("nowd_no_error", o_req_error, 0);
    egress_finished = 1'b1;
    step();
    egress_finished = 1'b0;
    step();
    chk("nowd_done", o_req_done, 3'b010);
    chk("nowd_error", o_req_error, 0);
`endif
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pcie_egress_arbiter.md
# pcie_egress_arbiter

Shares the single PCIe egress TLP engine between NUM_REQ requesters (e.g. completer, DMA write, DMA read-request paths). Round-robin arbitration; the winner's header fields and outgoing FIFO are routed to the engine, which is sequenced through its enable/finished handshake. Sits between the requester blocks and the egress engine in the PCIe platform slave.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- TIMEOUT_CYCLES, 65535, watchdog limit per transaction (used only with the watchdog macro)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_req_valid  in  NUM_REQ  per-requester transaction request
- i_req_command  in  NUM_REQ*8  TLP type (pcie_defines codes), slice k = requester k
- i_req_flags  in  NUM_REQ*14  header flags
- i_req_address  in  NUM_REQ*32  target address
- i_req_requester_id  in  NUM_REQ*16  requester ID
- i_req_tag  in  NUM_REQ*8  tag
- o_req_grant  out  NUM_REQ  one-cycle pulse: fields captured
- o_req_done  out  NUM_REQ  one-cycle pulse: transaction complete
- o_req_error  out  NUM_REQ  pulse with done when watchdog aborted
- i_req_fifo_rdy  in  NUM_REQ  requester FIFO ready
- i_req_fifo_size  in  NUM_REQ*24  requester FIFO DWORD count
- i_req_fifo_data  in  NUM_REQ*32  requester FIFO data
- o_req_fifo_act  out  NUM_REQ  routed FIFO activate
- o_req_fifo_stb  out  NUM_REQ  routed FIFO strobe
- o_egress_enable  out  1  engine enable
- i_egress_finished  in  1  engine finished
- o_egress_command / o_egress_flags / o_egress_address / o_egress_requester_id / o_egress_tag  out  8/14/32/16/8  registered header fields
- o_egress_fifo_rdy  out  1, o_egress_fifo_size  out  24, o_egress_fifo_data  out  32  routed FIFO to engine
- i_egress_fifo_act  in  1, i_egress_fifo_stb  in  1  engine FIFO controls
- o_busy  out  1  state is ISSUE or RELEASE

## Operation
- States: IDLE, ISSUE, RELEASE.
- IDLE: if any i_req_valid, pick first valid index searching from last_grant+1 modulo NUM_REQ; latch index into sel, latch its fields into o_egress_*, pulse o_req_grant[sel], set o_egress_enable, go ISSUE.
- Requester holds valid and fields stable until grant; may drop valid after grant. Valid without grant never times out.
- ISSUE: on i_egress_finished=1, clear o_egress_enable, go RELEASE.
- RELEASE: on i_egress_finished=0, pulse o_req_done[sel], last_grant<=sel, go IDLE.
- FIFO routing (combinational, only while o_busy): o_egress_fifo_rdy/size/data = requester sel; o_req_fifo_act[sel]=i_egress_fifo_act, o_req_fifo_stb[sel]=i_egress_fifo_stb; all other bits 0. In IDLE all routed outputs 0.
- Requests arriving during ISSUE/RELEASE wait; no pre-emption.

## Timing
- Reset: state IDLE, sel=0, last_grant=NUM_REQ-1 (requester 0 wins first), all registered outputs 0.
- Valid sampled at edge N -> grant pulse and o_egress_enable high after edge N (cycle N+1).
- finished sampled high at edge M -> enable low cycle M+1; finished sampled low at edge P -> done pulse cycle P+1, IDLE.
- Minimum spacing between grants: 3 cycles plus engine time; the IDLE cycle is mandatory.
- Simultaneous valids: strict rotation; a requester that just completed has lowest priority next.
- Reset mid-transaction: enable drops immediately, no done pulse emitted; requester must reissue.

## Configuration
- PCIE_EGRESS_ARB_WATCHDOG_EN defined: 32-bit counter cleared on entry to ISSUE, increments each ISSUE cycle; reaching TIMEOUT_CYCLES-1 clears enable, sets internal abort flag, goes RELEASE; done then pulses with o_req_error[sel].
- Undefined: no counter, ISSUE waits indefinitely, o_req_error tied 0.

## Structure
- State encodings and field widths as localparams in a shared package include (nysa_pcie_defines.v); TLP command codes remain in pcie_defines.v.
- Sub-module pcie_egress_rr_select: combinational round-robin picker (valid vector, last_grant -> index, any).

## Test plan
- Single req0 MRD (cmd 0x00, tag 0x05), engine finishes after 4 cycles -> grant[0] cycle 1, enable 4+ cycles, done[0] once, o_egress_tag=0x05.
- All three valid continuously -> grant order 0,1,2,0,1; no two grants within 3 cycles.
- Req1 write, fifo_size 16, engine strobes 16 times -> o_req_fifo_stb[1] 16 pulses, stb[0]/[2] stay 0, fifo_data matches requester 1.
- Watchdog on, TIMEOUT_CYCLES=10, finished never rises -> enable drops after 10 ISSUE cycles, done[sel] and error[sel] pulse together.
- Reset asserted mid-ISSUE -> enable and all outputs 0 asynchronously; after release req0 wins first.
- Req2 valid alone after req2 completed -> granted again (rotation skips nonvalid).
